miner_nonce_scheduler: RTL and testbench

- Shares a pool of NUM_CORES SHA-256 miner cores across one nonce range.
- Issues one nonce per cycle to the lowest-index idle core and tracks each core's in-flight nonce.
- Collects finished/hit results and reports the first golden nonce, or range exhaustion.
- Sits between the host/job interface and the array of miner_core_CCU-controlled cores; each core_start pulse drives a core's hash_enable.

---
 rtl/miner_nonce_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_miner_nonce_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_nonce_scheduler.sv
// Nonce scheduler: hands out one nonce per cycle to the lowest idle miner core and
// collects finish/hit results, reporting the first golden nonce or range exhaustion.
module miner_nonce_scheduler #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned CORE_IDX_W = $clog2(NUM_CORES)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           nonce_start,
  input  logic [31:0]           nonce_end,
  input  logic [NUM_CORES-1:0]  core_finished,
  input  logic [NUM_CORES-1:0]  core_hit,
  output logic [NUM_CORES-1:0]  core_start,
  output logic [31:0]           core_nonce,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [31:0]           golden_nonce,
  output logic [CORE_IDX_W-1:0] golden_core,
  output logic [31:0]           nonces_issued
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CORES-1:0]    core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]    core_start_q, core_start_d;
  logic [31:0]             core_nonce_q, core_nonce_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    found_q, found_d;
  logic [31:0]             golden_nonce_q, golden_nonce_d;
  logic [CORE_IDX_W-1:0]   golden_core_q, golden_core_d;
  logic [31:0]             nonces_issued_q, nonces_issued_d;
  logic [31:0]             next_nonce_q, next_nonce_d;
  logic [31:0]             end_q, end_d;
  logic                    exhausted_q, exhausted_d;
  logic [31:0]             inflight_q [NUM_CORES];
  logic [31:0]             inflight_d [NUM_CORES];

  logic [NUM_CORES-1:0]    fin_valid, hit_vec, busy_after_fin, disp_vec;
  logic                    free_any, hit_any, hit_take, dispatch;
  logic [CORE_IDX_W-1:0]   free_idx, hit_idx;

  // Finishes only count for cores we actually dispatched to.
  assign fin_valid      = core_finished & core_busy_q;
  assign hit_vec        = fin_valid & core_hit;
  assign busy_after_fin = core_busy_q & ~fin_valid;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    disp_vec = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!free_any && !core_busy_q[i]) begin
        free_any    = 1'b1;
        free_idx    = CORE_IDX_W'(i);
        disp_vec[i] = 1'b1;
      end
      if (!hit_any && hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = CORE_IDX_W'(i);
      end
    end
  end

  assign hit_take = (state_q == StRun) && !found_q && hit_any;
  // A hit or abort closes dispatch in the same cycle it is seen.
  assign dispatch = (state_q == StRun) && !exhausted_q && free_any && !hit_take && !abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (hit_take || abort)                      state_d = StDrain;
        else if (exhausted_q && busy_after_fin == '0) state_d = StDone;
      end
      StDrain: if (busy_after_fin == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_busy_d     = core_busy_q;
    core_start_d    = '0;
    core_nonce_d    = core_nonce_q;
    done_d          = 1'b0;
    found_d         = found_q;
    golden_nonce_d  = golden_nonce_q;
    golden_core_d   = golden_core_q;
    nonces_issued_d = nonces_issued_q;
    next_nonce_d    = next_nonce_q;
    end_d           = end_q;
    exhausted_d     = exhausted_q;
    inflight_d      = inflight_q;
    busy_d          = (state_d != StIdle);

    if (state_q == StIdle && start) begin
      next_nonce_d    = nonce_start;
      end_d           = nonce_end;
      exhausted_d     = 1'b0;
      found_d         = 1'b0;
      golden_nonce_d  = '0;
      golden_core_d   = '0;
      nonces_issued_d = '0;
      core_busy_d     = '0;
    end
    if (state_q == StRun || state_q == StDrain) begin
      core_busy_d = busy_after_fin;
    end
    if (dispatch) begin
      core_start_d         = disp_vec;
      core_nonce_d         = next_nonce_q;
      inflight_d[free_idx] = next_nonce_q;
      core_busy_d          = busy_after_fin | disp_vec;
      next_nonce_d         = next_nonce_q + 32'd1;
      nonces_issued_d      = nonces_issued_q + 32'd1;
      if (next_nonce_q == end_q) exhausted_d = 1'b1;
    end
    if (hit_take) begin
      found_d        = 1'b1;
      golden_nonce_d = inflight_q[hit_idx];
      golden_core_d  = hit_idx;
    end
    if (state_q == StDone) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      core_busy_q     <= '0;
      core_start_q    <= '0;
      core_nonce_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      found_q         <= 1'b0;
      golden_nonce_q  <= '0;
      golden_core_q   <= '0;
      nonces_issued_q <= '0;
      next_nonce_q    <= '0;
      end_q           <= '0;
      exhausted_q     <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) inflight_q[i] <= '0;
    end else begin
      core_busy_q     <= core_busy_d;
      core_start_q    <= core_start_d;
      core_nonce_q    <= core_nonce_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      found_q         <= found_d;
      golden_nonce_q  <= golden_nonce_d;
      golden_core_q   <= golden_core_d;
      nonces_issued_q <= nonces_issued_d;
      next_nonce_q    <= next_nonce_d;
      end_q           <= end_d;
      exhausted_q     <= exhausted_d;
      inflight_q      <= inflight_d;
    end
  end

  assign core_start    = core_start_q;
  assign core_nonce    = core_nonce_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;
  assign golden_nonce  = golden_nonce_q;
  assign golden_core   = golden_core_q;
  assign nonces_issued = nonces_issued_q;

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Scoreboard bench for miner_nonce_scheduler: expected dispatches are queued as jobs are
// driven and popped whenever the scheduler pulses core_start.
module tb_miner_nonce_scheduler;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start, abort;
  logic [31:0] nonce_start, nonce_end;
  logic [3:0]  core_finished, core_hit;
  logic [3:0]  core_start;
  logic [31:0] core_nonce;
  logic        busy, done, found;
  logic [31:0] golden_nonce;
  logic [1:0]  golden_core;
  logic [31:0] nonces_issued;

  miner_nonce_scheduler #(.NUM_CORES(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .abort         (abort),
    .nonce_start   (nonce_start),
    .nonce_end     (nonce_end),
    .core_finished (core_finished),
    .core_hit      (core_hit),
    .core_start    (core_start),
    .core_nonce    (core_nonce),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .golden_nonce  (golden_nonce),
    .golden_core   (golden_core),
    .nonces_issued (nonces_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vec;
    logic [31:0] nonce;
  } disp_t;

  disp_t       exp_q[$];
  logic [31:0] model_inflight [4];
  int          checks   = 0;
  int          failures = 0;
  bit          done_seen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_disp(input int core, input logic [31:0] nonce);
    disp_t d;
    d.vec   = 4'b0001 << core;
    d.nonce = nonce;
    exp_q.push_back(d);
  endtask

  // One clock; sample #1 after the edge and score any dispatch seen.
  task automatic step();
    disp_t d;
    @(posedge clk);
    #1;
    if (done) done_seen = 1'b1;
    if (core_start != 4'b0) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_start", {28'b0, core_start}, 32'h0);
      end else begin
        d = exp_q.pop_front();
        check_val("start_vec", {28'b0, core_start}, {28'b0, d.vec});
        check_val("start_nonce", core_nonce, d.nonce);
        for (int i = 0; i < 4; i++) if (d.vec[i]) model_inflight[i] = d.nonce;
      end
    end
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e);
    done_seen   = 1'b0;
    start       = 1'b1;
    nonce_start = s;
    nonce_end   = e;
    step();
    start = 1'b0;
  endtask

  task automatic finish(input int core, input bit hit);
    core_finished = 4'b0001 << core;
    core_hit      = hit ? (4'b0001 << core) : 4'b0;
    step();
    core_finished = 4'b0;
    core_hit      = 4'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      step();
      n++;
    end
    check_val(tag, {31'b0, done_seen}, 32'h1);
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; core_finished = '0; core_hit = '0;
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) model_inflight[i] = '0;
    #12;
    n_rst = 1'b1;
    run_steps(1);
    check_val("rst_busy", {31'b0, busy}, 32'h0);
    check_val("rst_found", {31'b0, found}, 32'h0);
    check_val("rst_issued", nonces_issued, 32'h0);
    check_val("rst_start", {28'b0, core_start}, 32'h0);

    // Basic fill
    for (int i = 0; i < 4; i++) push_disp(i, 32'h100 + i);
    start_job(32'h100, 32'h103);
    check_val("first_latency", {28'b0, core_start}, 32'h0);
    check_val("busy_run", {31'b0, busy}, 32'h1);
    run_steps(6);
    check_val("fill_issued", nonces_issued, 32'h4);
    for (int i = 0; i < 3; i++) finish(i, 1'b0);
    check_val("fill_not_done", {31'b0, done_seen}, 32'h0);
    finish(3, 1'b0);
    wait_done("fill_done", 5);
    check_val("fill_found", {31'b0, found}, 32'h0);
    check_val("fill_issued_end", nonces_issued, 32'h4);
    check_val("fill_busy_end", {31'b0, busy}, 32'h0);
    step();
    check_val("done_pulse", {31'b0, done}, 32'h0);

    // Single hit on core 2 while it holds nonce 6
    for (int i = 0; i < 4; i++) push_disp(i, i);
    start_job(32'h0, 32'hFF);
    run_steps(4);
    for (int k = 4; k <= 6; k++) begin
      push_disp(2, k);
      finish(2, 1'b0);
      step();
    end
    finish(2, 1'b1);
    check_val("hit_found", {31'b0, found}, 32'h1);
    check_val("hit_nonce", golden_nonce, 32'h6);
    check_val("hit_nonce_model", golden_nonce, model_inflight[2]);
    check_val("hit_core", {30'b0, golden_core}, 32'h2);
    check_val("hit_issued", nonces_issued, 32'h7);
    run_steps(3);
    finish(0, 1'b0);
    finish(1, 1'b0);
    check_val("hit_not_done", {31'b0, done_seen}, 32'h0);
    finish(3, 1'b0);
    wait_done("hit_done", 5);
    check_val("hit_found_kept", {31'b0, found}, 32'h1);

    // Simultaneous hits on cores 1 and 3; later hit from core 0 ignored
    for (int i = 0; i < 4; i++) push_disp(i, 32'h10 + i);
    start_job(32'h10, 32'h1F);
    run_steps(4);
    core_finished = 4'b1010; core_hit = 4'b1010;
    step();
    core_finished = 4'b0; core_hit = 4'b0;
    check_val("sim_core", {30'b0, golden_core}, 32'h1);
    check_val("sim_nonce", golden_nonce, 32'h11);
    finish(0, 1'b1);
    check_val("late_core", {30'b0, golden_core}, 32'h1);
    check_val("late_nonce", golden_nonce, 32'h11);
    finish(2, 1'b0);
    wait_done("sim_done", 5);

    // Wrap through zero, stray hits ignored
    push_disp(0, 32'hFFFF_FFFE); push_disp(1, 32'hFFFF_FFFF);
    push_disp(2, 32'h0);         push_disp(3, 32'h1);
    start_job(32'hFFFF_FFFE, 32'h1);
    run_steps(6);
    check_val("wrap_issued", nonces_issued, 32'h4);
    core_hit = 4'b1111;
    step();
    core_hit = 4'b0;
    check_val("hit_no_finish", {31'b0, found}, 32'h0);
    finish(0, 1'b0);
    finish(0, 1'b1);
    check_val("idle_core_hit", {31'b0, found}, 32'h0);
    finish(1, 1'b0);
    finish(2, 1'b0);
    finish(3, 1'b0);
    wait_done("wrap_done", 5);
    check_val("wrap_found", {31'b0, found}, 32'h0);

    // Recycling, ignored mid-run start, then abort
    for (int i = 0; i < 4; i++) push_disp(i, 32'h200 + i);
    start_job(32'h200, 32'h2FF);
    run_steps(4);
    start = 1'b1; nonce_start = 32'h900; nonce_end = 32'h9FF;
    step();
    start = 1'b0;
    push_disp(0, 32'h204);
    finish(0, 1'b0);
    check_val("no_same_cycle", {28'b0, core_start}, 32'h0);
    step();
    check_val("recycle_issued", nonces_issued, 32'h5);
    finish(1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_steps(3);
    check_val("abort_busy", {31'b0, busy}, 32'h1);
    check_val("abort_issued", nonces_issued, 32'h5);
    finish(0, 1'b0);
    finish(2, 1'b0);
    check_val("abort_not_done", {31'b0, done_seen}, 32'h0);
    finish(3, 1'b0);
    wait_done("abort_done", 5);
    check_val("abort_found", {31'b0, found}, 32'h0);

    // Reset mid-run
    push_disp(0, 32'h300); push_disp(1, 32'h301);
    start_job(32'h300, 32'h3FF);
    run_steps(2);
    n_rst = 1'b0;
    #1;
    check_val("mid_rst_busy", {31'b0, busy}, 32'h0);
    check_val("mid_rst_issued", nonces_issued, 32'h0);
    check_val("mid_rst_start", {28'b0, core_start}, 32'h0);
    check_val("mid_rst_nonce", core_nonce, 32'h0);
    #20;
    n_rst = 1'b1;
    run_steps(4);
    check_val("mid_rst_no_done", {31'b0, done_seen}, 32'h0);
    check_val("mid_rst_idle", {31'b0, busy}, 32'h0);
    check_val("queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
